// File: rtl/disp_arb_param_pkg.sv
// Shared defaults and lane-age convention for the dispatch-to-launch-buffer arbiter.
package disp_arb_param_pkg;
  localparam int DEF_DISP_W = 4;
  localparam int DEF_SLOT_N = 12;
  localparam int DEF_INST_W = 50;

  typedef enum logic {AGE_LSB_OLDEST = 1'b0, AGE_MSB_OLDEST = 1'b1} lane_age_e;
  localparam lane_age_e LANE_AGE = AGE_MSB_OLDEST;

  // Lane served at allocation stage k (stage 0 is the oldest lane).
  function automatic int age_lane(input int k, input int n);
    return (LANE_AGE == AGE_MSB_OLDEST) ? n - 1 - k : k;
  endfunction
endpackage

// File: rtl/disp_arb_param_rot_ffs.sv
// Find-first-set over req_i scanning upward from start_i with wrap; one-hot result.
module rot_ffs #(
  parameter int N  = 12,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic          found_o
);
  always_comb begin
    int idx;
    gnt_o   = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start_i) + k) % N;
      if (!found_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/disp_arb_param.sv
// Dispatch arbiter: oldest-first lane-to-slot allocation from a rotating pointer,
// registered slot write strobes and payloads one cycle after the grant.
module disp_arb_param
  import disp_arb_param_pkg::*;
#(
  parameter int DISP_W  = DEF_DISP_W,
  parameter int SLOT_N  = DEF_SLOT_N,
  parameter int INST_W  = DEF_INST_W,
  parameter int PARTIAL = 1,
  parameter int RR      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [DISP_W-1:0]            in_valid,
  input  logic [DISP_W*INST_W-1:0]     in_inst,
  output logic [DISP_W-1:0]            in_ready,
  input  logic [SLOT_N-1:0]            slot_empty,
  output logic [SLOT_N-1:0]            slot_wr,
  output logic [SLOT_N*INST_W-1:0]     slot_inst,
  output logic [$clog2(DISP_W+1)-1:0]  disp_cnt
);
  localparam int EC_W  = $clog2(DISP_W+1);
  localparam int AC_W  = $clog2(SLOT_N+1);
  localparam int PTR_W = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;

  if (SLOT_N < DISP_W) begin : g_bad_cfg
    $error("disp_arb_param: SLOT_N must be >= DISP_W");
  end

  logic [SLOT_N-1:0]                 avail;
  logic [DISP_W:0][SLOT_N-1:0]       mask;
  logic [DISP_W-1:0][SLOT_N-1:0]     hit;
  logic [DISP_W-1:0]                 found, stg_en, stg_gnt;
  logic [DISP_W-1:0][INST_W-1:0]     stg_inst;
  logic [EC_W-1:0]                   en_cnt;
  logic [AC_W-1:0]                   avail_cnt;
  logic                              fit;

  logic [PTR_W-1:0]                  ptr_q, ptr_d;
  logic [SLOT_N-1:0]                 slot_wr_q, slot_wr_d;
  logic [SLOT_N-1:0][INST_W-1:0]     slot_inst_q, slot_inst_d;
  logic [EC_W-1:0]                   disp_cnt_q, disp_cnt_d;

  // Slots with a write already in flight must not be handed out again.
  assign avail   = slot_empty & ~slot_wr_q;
  assign mask[0] = avail;

  for (genvar k = 0; k < DISP_W; k++) begin : g_stg
    localparam int L = age_lane(k, DISP_W);
    assign stg_en[k]   = in_valid[L];
    assign stg_inst[k] = in_inst[L*INST_W +: INST_W];
    rot_ffs #(.N(SLOT_N), .PW(PTR_W)) u_ffs (
      .req_i   (stg_en[k] ? mask[k] : '0),
      .start_i (ptr_q),
      .gnt_o   (hit[k]),
      .found_o (found[k])
    );
    assign mask[k+1]  = mask[k] & ~hit[k];
    // Masks only shrink, so a refused older lane implies every younger lane is refused.
    assign stg_gnt[k] = rst_n & ~flush & found[k] & ((PARTIAL != 0) | fit);
    assign in_ready[L] = stg_gnt[k];
  end

  always_comb begin
    en_cnt    = '0;
    avail_cnt = '0;
    for (int i = 0; i < DISP_W; i++) en_cnt    += EC_W'(in_valid[i]);
    for (int s = 0; s < SLOT_N; s++) avail_cnt += AC_W'(avail[s]);
    fit = (avail_cnt >= AC_W'(en_cnt));
  end

  always_comb begin
    slot_wr_d   = '0;
    slot_inst_d = '0;
    disp_cnt_d  = '0;
    ptr_d       = ptr_q;
    for (int k = 0; k < DISP_W; k++) begin
      if (stg_gnt[k]) begin
        slot_wr_d  |= hit[k];
        disp_cnt_d += EC_W'(1);
        for (int s = 0; s < SLOT_N; s++) begin
          if (hit[k][s]) begin
            slot_inst_d[s] = stg_inst[k];
            // Youngest granted lane lands furthest in scan order; it wins.
            if (RR != 0) ptr_d = (s == SLOT_N-1) ? '0 : PTR_W'(s + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      slot_wr_q   <= '0;
      slot_inst_q <= '0;
      disp_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      slot_wr_q   <= slot_wr_d;
      slot_inst_q <= slot_inst_d;
      disp_cnt_q  <= disp_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign slot_wr   = slot_wr_q;
  assign slot_inst = slot_inst_q;
  assign disp_cnt  = disp_cnt_q;
endmodule

// File: tb/tb_disp_arb_param.sv
// Bench: PARTIAL=1/RR=1 and PARTIAL=0/RR=0 instances share stimulus; queue-based model.
module tb_disp_arb_param;
  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [3:0]   in_valid;
  logic [199:0] in_inst;
  logic [11:0]  slot_empty;
  logic [3:0]   rdy  [2];
  logic [11:0]  wr   [2];
  logic [599:0] sinst[2];
  logic [2:0]   cnt  [2];

  logic [3:0]   p_rdy [2];
  logic [11:0]  p_wr  [2];
  logic [599:0] p_inst[2];
  int           p_cnt [2];
  int           p_ptr [2];
  logic [11:0]  m_wr  [2];
  logic [599:0] m_inst[2];
  int           m_cnt [2];
  int           m_ptr [2];

  int n_chk;
  int n_fail;

  disp_arb_param #(.PARTIAL(1), .RR(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(rdy[0]), .slot_empty(slot_empty), .slot_wr(wr[0]), .slot_inst(sinst[0]),
    .disp_cnt(cnt[0]));
  disp_arb_param #(.PARTIAL(0), .RR(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(rdy[1]), .slot_empty(slot_empty), .slot_wr(wr[1]), .slot_inst(sinst[1]),
    .disp_cnt(cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled lanes oldest-first, free slots in scan order; pair them up.
  function automatic void model(input int d, input bit partial, input bit rr);
    int en[$];
    int av[$];
    int n;
    for (int l = 3; l >= 0; l--) if (in_valid[l]) en.push_back(l);
    for (int k = 0; k < 12; k++) begin
      int s;
      s = (m_ptr[d] + k) % 12;
      if (slot_empty[s] && !m_wr[d][s]) av.push_back(s);
    end
    if (partial) n = (en.size() < av.size()) ? en.size() : av.size();
    else         n = (av.size() >= en.size()) ? en.size() : 0;
    if (!rst_n || flush) n = 0;
    p_rdy[d]  = '0;
    p_wr[d]   = '0;
    p_inst[d] = '0;
    for (int i = 0; i < n; i++) begin
      p_rdy[d][en[i]]         = 1'b1;
      p_wr[d][av[i]]          = 1'b1;
      p_inst[d][av[i]*50 +: 50] = in_inst[en[i]*50 +: 50];
    end
    p_cnt[d] = n;
    if (!rst_n || flush)  p_ptr[d] = 0;
    else if (rr && n > 0) p_ptr[d] = (av[n-1] + 1) % 12;
    else                  p_ptr[d] = m_ptr[d];
  endfunction

  task automatic drive(input logic [3:0] v, input logic [11:0] e, input logic f, input logic r);
    in_valid = v; slot_empty = e; flush = f; rst_n = r;
    for (int i = 0; i < 4; i++) in_inst[i*50 +: 50] = 50'({$urandom(), $urandom()});
    #1;
    model(0, 1'b1, 1'b1);
    model(1, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = p_wr[d]; m_inst[d] = p_inst[d]; m_cnt[d] = p_cnt[d]; m_ptr[d] = p_ptr[d];
    end
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 12'h000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    drive(4'b1111, 12'hFFF, 1'b0, 1'b0);
    n_chk++; if (rdy[0] !== 4'b0000 || rdy[1] !== 4'b0000) begin
      n_fail++; $display("FAIL reset_rdy got %b/%b exp 0000", rdy[0], rdy[1]); end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (wr[d] !== 12'h000 || cnt[d] !== 3'd0 || sinst[d] !== '0) begin
        n_fail++; $display("FAIL reset_out dut%0d wr=%h cnt=%0d exp 0", d, wr[d], cnt[d]); end
    end
  endtask

  task automatic test_full();
    logic [199:0] li;
    do_reset();
    drive(4'b1111, 12'hFFF, 1'b0, 1'b1);
    li = in_inst;
    n_chk++; if (rdy[0] !== 4'b1111 || rdy[1] !== 4'b1111) begin
      n_fail++; $display("FAIL full_rdy got %b/%b exp 1111", rdy[0], rdy[1]); end
    tick();
    n_chk++; if (wr[0] !== 12'h00F || cnt[0] !== 3'd4) begin
      n_fail++; $display("FAIL full_wr got %h cnt %0d exp 00f cnt 4", wr[0], cnt[0]); end
    n_chk++; if (sinst[0][0 +: 50] !== li[150 +: 50] || sinst[0][150 +: 50] !== li[0 +: 50]) begin
      n_fail++; $display("FAIL full_inst slot0=%h slot3=%h exp %h %h", sinst[0][0 +: 50],
                         sinst[0][150 +: 50], li[150 +: 50], li[0 +: 50]); end
    // Pointer now at 4: next single grant lands in slot 4.
    drive(4'b1000, 12'hFFF, 1'b0, 1'b1);
    tick();
    n_chk++; if (wr[0] !== 12'h010) begin
      n_fail++; $display("FAIL full_ptr got %h exp 010", wr[0]); end
  endtask

  task automatic test_partial();
    logic [199:0] li;
    do_reset();
    drive(4'b1111, 12'h005, 1'b0, 1'b1);
    li = in_inst;
    n_chk++; if (rdy[0] !== 4'b1100) begin
      n_fail++; $display("FAIL partial_rdy got %b exp 1100", rdy[0]); end
    n_chk++; if (rdy[1] !== 4'b0000) begin
      n_fail++; $display("FAIL aon_rdy got %b exp 0000", rdy[1]); end
    tick();
    n_chk++; if (wr[0] !== 12'h005 || cnt[0] !== 3'd2 || sinst[0][0 +: 50] !== li[150 +: 50]
                 || sinst[0][100 +: 50] !== li[100 +: 50]) begin
      n_fail++; $display("FAIL partial_out wr=%h cnt=%0d exp 005 cnt 2", wr[0], cnt[0]); end
    n_chk++; if (wr[1] !== 12'h000 || cnt[1] !== 3'd0) begin
      n_fail++; $display("FAIL aon_out wr=%h cnt=%0d exp 0", wr[1], cnt[1]); end
  endtask

  task automatic test_wrap();
    logic [199:0] li;
    do_reset();
    drive(4'b1000, 12'h400, 1'b0, 1'b1);
    tick();
    drive(4'b0110, 12'hFFF, 1'b0, 1'b1);
    li = in_inst;
    n_chk++; if (rdy[0] !== 4'b0110) begin
      n_fail++; $display("FAIL wrap_rdy got %b exp 0110", rdy[0]); end
    tick();
    n_chk++; if (wr[0] !== 12'h801 || sinst[0][550 +: 50] !== li[100 +: 50]
                 || sinst[0][0 +: 50] !== li[50 +: 50]) begin
      n_fail++; $display("FAIL wrap_out wr=%h exp 801", wr[0]); end
    drive(4'b1000, 12'hFFF, 1'b0, 1'b1);
    tick();
    n_chk++; if (wr[0] !== 12'h002) begin
      n_fail++; $display("FAIL wrap_ptr got %h exp 002", wr[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'b0011, 12'h003, 1'b0, 1'b1);
    tick();
    n_chk++; if (wr[0] !== 12'h003 || wr[1] !== 12'h003) begin
      n_fail++; $display("FAIL b2b_first got %h/%h exp 003", wr[0], wr[1]); end
    drive(4'b0011, 12'h003, 1'b0, 1'b1);
    n_chk++; if (rdy[0] !== 4'b0000 || rdy[1] !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_rdy got %b/%b exp 0000", rdy[0], rdy[1]); end
    tick();
    n_chk++; if (wr[0] !== 12'h000 || wr[1] !== 12'h000) begin
      n_fail++; $display("FAIL b2b_second got %h/%h exp 000", wr[0], wr[1]); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    drive(4'b1111, 12'hFFF, 1'b0, 1'b1);
    tick();
    drive(4'b1111, 12'hFFF, 1'b1, 1'b1);
    n_chk++; if (rdy[0] !== 4'b0000 || rdy[1] !== 4'b0000) begin
      n_fail++; $display("FAIL flush_rdy got %b/%b exp 0000", rdy[0], rdy[1]); end
    tick();
    n_chk++; if (wr[0] !== 12'h000 || cnt[0] !== 3'd0 || sinst[0] !== '0) begin
      n_fail++; $display("FAIL flush_out wr=%h cnt=%0d exp 0", wr[0], cnt[0]); end
    drive(4'b1000, 12'hFFF, 1'b0, 1'b1);
    tick();
    n_chk++; if (wr[0] !== 12'h001) begin
      n_fail++; $display("FAIL flush_ptr got %h exp 001", wr[0]); end
    drive(4'b1111, 12'hFFF, 1'b1, 1'b0);
    n_chk++; if (rdy[0] !== 4'b0000 || rdy[1] !== 4'b0000) begin
      n_fail++; $display("FAIL rst_rdy got %b/%b exp 0000", rdy[0], rdy[1]); end
    tick();
    n_chk++; if (wr[0] !== 12'h000 || cnt[0] !== 3'd0 || sinst[0] !== '0 || wr[1] !== 12'h000) begin
      n_fail++; $display("FAIL rst_out wr=%h/%h cnt=%0d exp 0", wr[0], wr[1], cnt[0]); end
    drive(4'b1000, 12'hFFF, 1'b0, 1'b1);
    tick();
    n_chk++; if (wr[0] !== 12'h001) begin
      n_fail++; $display("FAIL rst_ptr got %h exp 001", wr[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic f, r;
      f = ($urandom_range(15) == 0);
      r = ($urandom_range(63) != 0);
      drive(4'($urandom()), 12'($urandom()) | 12'($urandom()), f, r);
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (rdy[d] !== p_rdy[d]) begin
          n_fail++; $display("FAIL rand_rdy c%0d dut%0d got %b exp %b", c, d, rdy[d], p_rdy[d]); end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (wr[d] !== m_wr[d]) begin
          n_fail++; $display("FAIL rand_wr c%0d dut%0d got %h exp %h", c, d, wr[d], m_wr[d]); end
        n_chk++; if (sinst[d] !== m_inst[d]) begin
          n_fail++; $display("FAIL rand_inst c%0d dut%0d payload differs", c, d); end
        n_chk++; if (int'(cnt[d]) != m_cnt[d]) begin
          n_fail++; $display("FAIL rand_cnt c%0d dut%0d got %0d exp %0d", c, d, cnt[d], m_cnt[d]); end
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = '0; slot_empty = '0; in_inst = '0;
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = '0; m_inst[d] = '0; m_cnt[d] = 0; m_ptr[d] = 0;
    end
    @(negedge clk);
    test_reset();
    test_full();
    test_partial();
    test_wrap();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_arb_param.md
DISP_ARB_PARAM -- requirements
Module: disp_arb_param

Interface
REQ-001 SHALL have parameter DISP_W, default 4: number of dispatch lanes.
REQ-002 SHALL have parameter SLOT_N, default 12: number of launch-buffer slots; SLOT_N >= DISP_W, otherwise elaboration fails.
REQ-003 SHALL have parameter INST_W, default 50: instruction payload width.
REQ-004 SHALL have parameter PARTIAL, default 1: 1 = in-order prefix dispatch; 0 = all-or-nothing dispatch.
REQ-005 SHALL have parameter RR, default 1: 1 = rotating search start; 0 = search always starts at slot 0.
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 flush  in  1  pipeline kill.
REQ-010 in_valid  in  DISP_W  per-lane enable; lane DISP_W-1 is oldest.
REQ-011 in_inst  in  DISP_W*INST_W  lane payloads; lane i occupies bits [i*INST_W +: INST_W].
REQ-012 in_ready  out  DISP_W  per-lane accept, combinational, same cycle.
REQ-013 slot_empty  in  SLOT_N  launch-buffer free flags.
REQ-014 slot_wr  out  SLOT_N  registered one-hot-per-grant write strobes.
REQ-015 slot_inst  out  SLOT_N*INST_W  registered payload per slot.
REQ-016 disp_cnt  out  $clog2(DISP_W+1)  registered number of slots written.

Function
REQ-017 Available slots SHALL be slot_empty & ~slot_wr: slots with an in-flight registered write are never reallocated.
REQ-018 Enabled lanes SHALL be allocated oldest-first (descending lane index); disabled lanes consume no slot.
REQ-019 Each enabled lane SHALL take the first available slot not taken by an older lane, scanning upward from ptr modulo SLOT_N (wrap 11->0 at the default).
REQ-020 PARTIAL=0: all enabled lanes are granted when avail_cnt >= en_cnt; otherwise no lane is granted.
REQ-021 PARTIAL=1: the oldest min(en_cnt, avail_cnt) enabled lanes are granted; a younger lane is never granted while an older enabled lane is refused.
REQ-022 in_ready[i] SHALL be 1 only for granted lanes; upstream holds refused lanes for the next cycle.
REQ-023 At the next rising edge, slot_wr SHALL set exactly the granted slots, slot_inst SHALL carry the corresponding payload, and non-written slots SHALL be zero; latency is 1 cycle.
REQ-024 disp_cnt SHALL equal the popcount of the registered slot_wr.
REQ-025 RR=1: after any grant, ptr <= (highest-scan-order allocated slot + 1) mod SLOT_N; with no grant, ptr holds. RR=0: ptr is fixed at 0.
REQ-026 flush=1 SHALL force in_ready=0 in the same cycle; at the next edge slot_wr=0, disp_cnt=0 and ptr=0. Flush has priority over any grant.
REQ-027 With in_valid=0 or avail=0, there SHALL be no grant, slot_wr becomes 0 at the next edge, and ptr holds.
REQ-028 en_cnt and avail_cnt SHALL be computed at full width without truncation: $clog2(DISP_W+1) and $clog2(SLOT_N+1) bits respectively.

Reset
REQ-029 When rst_n=0 at a rising edge: slot_wr=0, slot_inst=0, disp_cnt=0, ptr=0; in_ready=0 while rst_n=0.
REQ-030 Reset asserted in the same cycle as a grant SHALL discard that grant; reset has priority over flush.

Structure
REQ-031 The default DISP_W, SLOT_N and INST_W values and the lane-age convention SHALL reside in the shared core package.
REQ-032 The block SHALL contain one sub-module, rot_ffs: masked find-first-set from a rotating start, returning a one-hot result and a found flag, chained DISP_W times.

Verification
REQ-033 Default params, in_valid=4'b1111, slot_empty=12'hFFF, ptr=0 -> in_ready=1111; next cycle slot_wr=12'h00F with lane3 in slot0 through lane0 in slot3; disp_cnt=4; ptr=4.
REQ-034 PARTIAL=1, in_valid=1111, slot_empty=12'h005 -> in_ready=1100; lane3 to slot0, lane2 to slot2; disp_cnt=2.
REQ-035 PARTIAL=0, same stimulus as REQ-034 -> in_ready=0000; next cycle slot_wr=0, ptr unchanged.
REQ-036 ptr=11, in_valid=0110, slot_empty=12'hFFF -> lane2 to slot11, lane1 to slot0; ptr=1.
REQ-037 Back-to-back cycles with slot_empty held at 12'h003 -> second cycle grants nothing (in-flight mask).
REQ-038 Flush, then rst_n=0 during an active grant -> in_ready=0; next edge all outputs zero and ptr=0.
